// File: rtl/sdram_burst_reader.sv
// sdram_burst_reader: Avalon-MM burst read master that streams a contiguous run of
// SDRAM words out over a valid/ready interface through a credit-protected FIFO.
// Optional feature macro: SDRAM_READER_BOUNDARY_EN keeps every burst inside a
// BURST_LEN-aligned window, so an unaligned base produces a short first burst.
module sdram_burst_reader #(
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned FIFO_DEPTH  = 32,
    parameter int unsigned COUNT_WIDTH = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [29:0]            base_address,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic [29:0]            avm_address,
    output logic [7:0]             avm_burstcount,
    output logic                   avm_read,
    input  logic                   avm_waitrequest,
    input  logic [31:0]            avm_readdata,
    input  logic                   avm_readdatavalid,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned OccW = PtrW + 1;

`ifdef SDRAM_READER_BOUNDARY_EN
    localparam bit BoundaryEn = 1'b1;
`else
    localparam bit BoundaryEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                 state_q;
    logic [COUNT_WIDTH-1:0] remaining_q, total_q, delivered_q;
    logic [OccW-1:0]        outstanding_q, fifo_count_q;
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [31:0]            mem_q [FIFO_DEPTH];

    logic                   accept, push, pop, can_issue;
    logic [29:0]            nxt_addr;
    logic [COUNT_WIDTH-1:0] nxt_rem, delivered_d;
    logic [7:0]             nxt_burst;
    logic [31:0]            credit_used;

    // Words for the next command: capped by BURST_LEN (or the aligned window) and by what is left.
    function automatic logic [7:0] burst_len(input logic [29:0] addr,
                                             input logic [COUNT_WIDTH-1:0] rem);
        logic [31:0] lim;
        logic [31:0] rem32;
        lim   = BoundaryEn ? (32'(BURST_LEN) - 32'(addr % 30'(BURST_LEN))) : 32'(BURST_LEN);
        rem32 = 32'(rem);
        return 8'((rem32 < lim) ? rem32 : lim);
    endfunction

    assign accept    = avm_read && !avm_waitrequest;
    // Returns with nothing outstanding are stale (e.g. in flight across a reset) and dropped.
    assign push      = avm_readdatavalid && (outstanding_q != '0);
    assign out_valid = (fifo_count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q];

    // Next command candidate and credit check, accounting for a command accepted this cycle.
    always_comb begin
        nxt_addr    = avm_address;
        nxt_rem     = remaining_q;
        if (accept) begin
            nxt_addr = avm_address + 30'(avm_burstcount);
            nxt_rem  = remaining_q - COUNT_WIDTH'(avm_burstcount);
        end
        nxt_burst   = burst_len(nxt_addr, nxt_rem);
        // Pops this cycle are ignored, which only makes the check conservative.
        credit_used = 32'(fifo_count_q) + 32'(outstanding_q)
                    + (accept ? 32'(avm_burstcount) : 32'd0);
        can_issue   = (nxt_rem != '0) && (!avm_read || accept)
                    && (credit_used + 32'(nxt_burst) <= 32'(FIFO_DEPTH));
        delivered_d = delivered_q + COUNT_WIDTH'(pop);
    end

    // Control FSM with registered bus and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            busy           <= 1'b0;
            done           <= 1'b0;
            avm_read       <= 1'b0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            remaining_q    <= '0;
            total_q        <= '0;
            delivered_q    <= '0;
        end else begin
            done        <= 1'b0;
            delivered_q <= delivered_d;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        total_q     <= word_count;
                        remaining_q <= word_count;
                        delivered_q <= '0;
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            // FIFO is empty here, so the first burst always has credit.
                            busy           <= 1'b1;
                            avm_read       <= 1'b1;
                            avm_address    <= base_address;
                            avm_burstcount <= burst_len(base_address, word_count);
                            state_q        <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    remaining_q <= nxt_rem;
                    if (can_issue) begin
                        avm_read       <= 1'b1;
                        avm_address    <= nxt_addr;
                        avm_burstcount <= nxt_burst;
                    end else if (accept) begin
                        avm_read    <= 1'b0;
                        avm_address <= nxt_addr;
                    end
                    if (accept && nxt_rem == '0) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (delivered_d == total_q) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FIFO pointers, occupancy and outstanding-word credit.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
            outstanding_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            fifo_count_q  <= fifo_count_q + OccW'(push) - OccW'(pop);
            outstanding_q <= outstanding_q + (accept ? OccW'(avm_burstcount) : OccW'(0))
                           - OccW'(push);
        end
    end

    // Read-data storage; contents need no reset since pointers define validity.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= avm_readdata;
    end

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Bench for sdram_burst_reader: Avalon slave model with fixed read latency, a
// stream/command model computed from the address arithmetic, and directed tests.
module tb_sdram_burst_reader;

    localparam int unsigned BL = 8;
    localparam int unsigned FD = 16;
    localparam int unsigned CW = 24;

    logic          clock = 1'b0;
    logic          reset, start;
    logic [29:0]   base_address;
    logic [CW-1:0] word_count;
    logic          busy, done;
    logic [29:0]   avm_address;
    logic [7:0]    avm_burstcount;
    logic          avm_read, avm_waitrequest;
    logic [31:0]   avm_readdata;
    logic          avm_readdatavalid;
    logic [31:0]   out_data;
    logic          out_valid, out_ready;

    always #5 clock = ~clock;

    sdram_burst_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .start(start), .base_address(base_address),
        .word_count(word_count), .busy(busy), .done(done), .avm_address(avm_address),
        .avm_burstcount(avm_burstcount), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    int total = 0, bad = 0, cyc = 0;
    logic [31:0] exp_data[$];
    logic [29:0] exp_addr[$];
    int          exp_bc[$];
    logic [29:0] obs_addr[$];
    int          obs_bc[$];
    logic [29:0] ret_addr[$];
    int          ret_cyc[$];
    int m_outst = 0, m_occ = 0, done_cnt = 0, stall_cnt = 0, wait_left = 0;
    int ready_mode = 1;  // 0: low, 1: high, 2: random
    bit          prev_stall = 1'b0;
    logic [29:0] prev_addr;
    logic [7:0]  prev_bc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [29:0] a);
        return {2'b01, a} ^ 32'h0F0F_0000;
    endfunction

    // Expected stream and command list for one transfer.
    task automatic plan(input logic [29:0] b, input int n);
        logic [29:0] a;
        int rem, lim, bc;
        for (int i = 0; i < n; i++) exp_data.push_back(word_at(b + 30'(i)));
        a = b;
        rem = n;
        while (rem > 0) begin
            lim = int'(BL);
`ifdef SDRAM_READER_BOUNDARY_EN
            lim = int'(BL) - (int'(a) % int'(BL));
`endif
            bc = (rem < lim) ? rem : lim;
            exp_addr.push_back(a);
            exp_bc.push_back(bc);
            a = a + 30'(bc);
            rem -= bc;
        end
    endtask

    // Slave and sink drivers, updated just after each rising edge.
    always @(posedge clock) begin
        cyc++;
        #1;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'hDEAD_BEEF;
        if (ret_addr.size() > 0 && ret_cyc[0] <= cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = word_at(ret_addr.pop_front());
            void'(ret_cyc.pop_front());
        end
        if (avm_read && wait_left > 0) begin
            avm_waitrequest = 1'b1;
            wait_left--;
        end else begin
            avm_waitrequest = 1'b0;
        end
        case (ready_mode)
            0:       out_ready = 1'b0;
            2:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clock) begin
        if (reset) begin
            m_outst = 0;
            m_occ = 0;
            prev_stall = 1'b0;
            exp_data.delete();
            exp_addr.delete();
            exp_bc.delete();
        end else begin
            if (prev_stall) begin
                chk("stall_hold_read", avm_read, 1);
                chk("stall_hold_addr", avm_address, prev_addr);
                chk("stall_hold_bc", avm_burstcount, prev_bc);
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            prev_bc    = avm_burstcount;
            if (prev_stall) stall_cnt++;
            chk("out_valid", out_valid, m_occ > 0);
            chk("credit_bound", (m_occ + m_outst) <= int'(FD), 1);
            if (avm_readdatavalid && m_outst > 0) begin
                m_outst--;
                m_occ++;
            end
            if (avm_read && !avm_waitrequest) begin : accept_blk
                int t;
                obs_addr.push_back(avm_address);
                obs_bc.push_back(int'(avm_burstcount));
                chk("cmd_expected", exp_addr.size() > 0, 1);
                if (exp_addr.size() > 0) begin
                    chk("cmd_addr", avm_address, exp_addr.pop_front());
                    chk("cmd_bc", avm_burstcount, exp_bc.pop_front());
                end
                m_outst += int'(avm_burstcount);
                t = cyc + 3;
                if (ret_cyc.size() > 0 && ret_cyc[$] >= t) t = ret_cyc[$] + 1;
                for (int k = 0; k < int'(avm_burstcount); k++) begin
                    ret_addr.push_back(avm_address + 30'(k));
                    ret_cyc.push_back(t + k);
                end
            end
            if (out_valid && out_ready) begin
                chk("stream_expected", exp_data.size() > 0, 1);
                if (exp_data.size() > 0) chk("stream_data", out_data, exp_data.pop_front());
                if (m_occ > 0) m_occ--;
            end
            if (done) begin
                done_cnt++;
                chk("done_all_words", exp_data.size(), 0);
                chk("done_busy_low", busy, 0);
            end
        end
    end

    task automatic do_start(input logic [29:0] b, input int n);
        @(posedge clock);
        #1;
        plan(b, n);
        start        = 1'b1;
        base_address = b;
        word_count   = CW'(n);
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_within_limit", seen, 1);
        repeat (3) @(negedge clock);
        chk("after_done_busy", busy, 0);
        chk("after_done_cmds_used", exp_addr.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mark, d0, s0;
        reset = 1'b1; start = 1'b0; base_address = '0; word_count = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_bc", avm_burstcount, 0);
        chk("rst_out_valid", out_valid, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Two full bursts, back to back.
        mark = obs_addr.size(); d0 = done_cnt;
        do_start(30'h100, 16);
        @(negedge clock);
        chk("t1_read_at_n1", avm_read, 1);
        chk("t1_busy_at_n1", busy, 1);
        wait_done(200);
        chk("t1_ncmd", obs_addr.size() - mark, 2);
        chk("t1_cmd0_addr", obs_addr[mark], 30'h100);
        chk("t1_cmd0_bc", obs_bc[mark], 8);
        chk("t1_cmd1_addr", obs_addr[mark+1], 30'h108);
        chk("t1_cmd1_bc", obs_bc[mark+1], 8);
        chk("t1_done_once", done_cnt - d0, 1);

        // Short single burst.
        mark = obs_addr.size();
        do_start(30'h40, 5);
        wait_done(100);
        chk("t2_ncmd", obs_addr.size() - mark, 1);
        chk("t2_bc", obs_bc[mark], 5);

        // Waitrequest stall on the first command.
        mark = obs_addr.size(); s0 = stall_cnt; wait_left = 4;
        do_start(30'h500, 8);
        wait_done(100);
        chk("t3_stall_cycles", stall_cnt - s0, 4);
        chk("t3_ncmd", obs_addr.size() - mark, 1);

        // Credit limit with a blocked sink.
        mark = obs_addr.size(); ready_mode = 0;
        do_start(30'h1000, 64);
        repeat (40) @(negedge clock);
        chk("t4_ncmd_blocked", obs_addr.size() - mark, 2);
        chk("t4_read_low", avm_read, 0);
        chk("t4_full_valid", out_valid, 1);
        ready_mode = 1;
        wait_done(600);
        chk("t4_ncmd_total", obs_addr.size() - mark, 8);

        // Zero-length request.
        mark = obs_addr.size(); d0 = done_cnt;
        do_start(30'h77, 0);
        @(negedge clock);
        chk("t5_done_n1", done, 1);
        chk("t5_busy", busy, 0);
        chk("t5_read", avm_read, 0);
        repeat (5) @(negedge clock);
        chk("t5_done_once", done_cnt - d0, 1);
        chk("t5_ncmd", obs_addr.size() - mark, 0);

        // Reset in the middle of a transfer, then a fresh one.
        d0 = done_cnt;
        do_start(30'h300, 32);
        repeat (6) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("t6_busy_clr", busy, 0);
        chk("t6_read_clr", avm_read, 0);
        chk("t6_valid_clr", out_valid, 0);
        for (int i = 0; i < 100 && ret_addr.size() > 0; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        chk("t6_stale_drained", ret_addr.size(), 0);
        chk("t6_no_done", done_cnt - d0, 0);
        mark = obs_addr.size();
        do_start(30'h200, 8);
        wait_done(100);
        chk("t6_restart_addr", obs_addr[mark], 30'h200);

        // Address wrap with a randomly stalling sink.
        ready_mode = 2;
        do_start(30'h3FFF_FFFC, 12);
        wait_done(400);
        ready_mode = 1;

        // Unaligned base.
        mark = obs_addr.size();
        do_start(30'h103, 16);
        wait_done(200);
`ifdef SDRAM_READER_BOUNDARY_EN
        chk("t8_ncmd", obs_addr.size() - mark, 3);
        chk("t8_bc0", obs_bc[mark], 5);
        chk("t8_addr1", obs_addr[mark+1], 30'h108);
        chk("t8_bc1", obs_bc[mark+1], 8);
        chk("t8_addr2", obs_addr[mark+2], 30'h110);
        chk("t8_bc2", obs_bc[mark+2], 3);
`else
        chk("t8_ncmd", obs_addr.size() - mark, 2);
        chk("t8_bc0", obs_bc[mark], 8);
        chk("t8_addr1", obs_addr[mark+1], 30'h10B);
        chk("t8_bc1", obs_bc[mark+1], 8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
